// File: rtl/tile_feeder_if.sv
// Handshake bundle between the pixel source, tile_feeder and the downstream edge detector.
interface tile_feeder_if #(
    parameter int BIT_LENGTH = 5
);
    logic [BIT_LENGTH-1:0] pix_in;
    logic                  pix_valid;
    logic                  pix_ready;
    logic [BIT_LENGTH-1:0] pixel_out0;
    logic [BIT_LENGTH-1:0] pixel_out1;
    logic [BIT_LENGTH-1:0] pixel_out2;
    logic [BIT_LENGTH-1:0] pixel_out3;
    logic [BIT_LENGTH-1:0] pixel_out4;
    logic                  load_end;
    logic                  readable;
    logic                  chip_rst;
    logic                  tile_done;
    logic [7:0]            tile_cnt;

    modport slave (
        input  pix_in, pix_valid, readable,
        output pix_ready, pixel_out0, pixel_out1, pixel_out2, pixel_out3, pixel_out4,
        output load_end, chip_rst, tile_done, tile_cnt
    );

    modport master (
        output pix_in, pix_valid, readable,
        input  pix_ready, pixel_out0, pixel_out1, pixel_out2, pixel_out3, pixel_out4,
        input  load_end, chip_rst, tile_done, tile_cnt
    );
endinterface

// File: rtl/tile_feeder.sv
// Buffers one serial 20x20 tile, replays it as 5-lane beats to the edge detector,
// then waits for the detector to drain before pulsing its reset and accepting the next tile.
module tile_feeder #(
    parameter int BIT_LENGTH = 5,
    parameter int TILE_PIX   = 400,
    parameter int BEATS      = 80,
    parameter int OUT_PIX    = 324
) (
    input  logic         clk,
    input  logic         reset,
    tile_feeder_if.slave bus
);
    localparam int WR_W   = $clog2(TILE_PIX + 1);
    localparam int BEAT_W = $clog2(BEATS + 1);
    localparam int RD_W   = $clog2(OUT_PIX + 1);

    typedef enum logic [1:0] {FILL, STREAM, HOLD, RST} state_e;

    state_e                state_q, state_d;
    logic [WR_W-1:0]       wr_cnt_q, wr_cnt_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [RD_W-1:0]       rd_cnt_q, rd_cnt_d;
    logic [7:0]            tile_cnt_q, tile_cnt_d;
    logic [BIT_LENGTH-1:0] lane_q [5];
    logic [BIT_LENGTH-1:0] lane_d [5];
    logic [BIT_LENGTH-1:0] tile_mem_q [TILE_PIX];

    logic                  wr_en;
    logic [BEAT_W-1:0]     rd_beat;
    logic [WR_W-1:0]       rd_base;
    logic                  drain_hit;

    // Beat 0 is fetched while the last pixel is being accepted, so the lanes are valid on STREAM entry
    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        beat_d     = beat_q;
        rd_cnt_d   = rd_cnt_q;
        tile_cnt_d = tile_cnt_q;
        wr_en      = 1'b0;
        for (int n = 0; n < 5; n++) lane_d[n] = lane_q[n];

        rd_beat   = (state_q == STREAM) ? beat_q : '0;
        rd_base   = WR_W'(rd_beat) * WR_W'(5);
        drain_hit = ((state_q == STREAM) || (state_q == HOLD)) && bus.readable;

        case (state_q)
            FILL: begin
                if (bus.pix_valid) begin
                    wr_en = 1'b1;
                    if (wr_cnt_q == WR_W'(TILE_PIX - 1)) begin
                        wr_cnt_d = '0;
                        beat_d   = BEAT_W'(1);
                        state_d  = STREAM;
                        for (int n = 0; n < 5; n++) lane_d[n] = tile_mem_q[rd_base + WR_W'(n)];
                    end else begin
                        wr_cnt_d = wr_cnt_q + WR_W'(1);
                    end
                end
            end
            STREAM: begin
                for (int n = 0; n < 5; n++) lane_d[n] = tile_mem_q[rd_base + WR_W'(n)];
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    beat_d  = '0;
                    state_d = HOLD;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            HOLD: begin
            end
            RST: begin
                state_d = FILL;
            end
            default: begin
                state_d = FILL;
            end
        endcase

        // The drain count overrides streaming so the tile always closes on the last edge bit
        if (drain_hit) begin
            if (rd_cnt_q == RD_W'(OUT_PIX - 1)) begin
                rd_cnt_d   = '0;
                beat_d     = '0;
                tile_cnt_d = tile_cnt_q + 8'd1;
                state_d    = RST;
                for (int n = 0; n < 5; n++) lane_d[n] = '0;
            end else begin
                rd_cnt_d = rd_cnt_q + RD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FILL;
            wr_cnt_q   <= '0;
            beat_q     <= '0;
            rd_cnt_q   <= '0;
            tile_cnt_q <= '0;
            for (int n = 0; n < 5; n++) lane_q[n] <= '0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            beat_q     <= beat_d;
            rd_cnt_q   <= rd_cnt_d;
            tile_cnt_q <= tile_cnt_d;
            for (int n = 0; n < 5; n++) lane_q[n] <= lane_d[n];
        end
    end

    // The buffer is never cleared; every location is rewritten during FILL before it is replayed
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            tile_mem_q[wr_cnt_q] <= bus.pix_in;
        end
    end

    assign bus.pix_ready  = (state_q == FILL);
    assign bus.load_end   = (state_q == HOLD);
    assign bus.chip_rst   = (state_q == RST);
    assign bus.tile_done  = (state_q == RST);
    assign bus.tile_cnt   = tile_cnt_q;
    assign bus.pixel_out0 = lane_q[0];
    assign bus.pixel_out1 = lane_q[1];
    assign bus.pixel_out2 = lane_q[2];
    assign bus.pixel_out3 = lane_q[3];
    assign bus.pixel_out4 = lane_q[4];
endmodule

// File: tb/tb_tile_feeder.sv
// Scoreboard bench for tile_feeder: a tile-level reference model queues expected beats and drain
// events; monitors compare them as the DUT presents them. A small second instance exercises tile_cnt wrap.
module tb_tile_feeder;
    localparam int BL  = 5;
    localparam int TP  = 400;
    localparam int NB  = 80;
    localparam int OP  = 324;
    localparam int STP = 10;
    localparam int SNB = 2;
    localparam int SOP = 4;
    localparam int SMALL_TILES = 257;

    typedef logic [4:0][BL-1:0] beat_t;
    typedef struct packed {
        logic [7:0]  cnt;
        logic [31:0] edgeNo;
    } done_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic resetS = 1'b1;
    always #5 clk = ~clk;

    tile_feeder_if #(.BIT_LENGTH(BL)) bus ();
    tile_feeder_if #(.BIT_LENGTH(BL)) busS ();

    tile_feeder #(.BIT_LENGTH(BL), .TILE_PIX(TP), .BEATS(NB), .OUT_PIX(OP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    tile_feeder #(.BIT_LENGTH(BL), .TILE_PIX(STP), .BEATS(SNB), .OUT_PIX(SOP)) dutSmall (
        .clk   (clk),
        .reset (resetS),
        .bus   (busS)
    );

    int total = 0;
    int bad = 0;
    int edgeCnt = 0;

    beat_t beatQ[$];
    done_t doneQ[$];

    logic [BL-1:0] tilePix [TP];
    int  accepted = 0;
    bit  loaded = 1'b0;
    bit  inRst = 1'b0;
    int  readCount = 0;
    int  tilesDone = 0;
    bit  expFill = 1'b1;
    bit  started = 1'b0;

    int  beatSeen = 0;
    beat_t lastBeat = '0;
    int  smallDone = 0;
    bit  smallRunning = 1'b0;
    bit  smallFinished = 1'b0;

    always @(posedge clk) edgeCnt = edgeCnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h (edge %0d)", name, actual, expected, edgeCnt);
        end
    endtask

    // Tile-level reference: collect accepted pixels, emit all beats once the tile is full,
    // then count detector reads until the tile drains, followed by one idle reset cycle.
    task automatic modelEdge(input bit v, input logic [BL-1:0] p, input bit rd);
        beat_t b;
        done_t d;
        if (inRst) begin
            inRst = 1'b0;
        end else if (!loaded) begin
            if (v) begin
                tilePix[accepted] = p;
                accepted++;
                if (accepted == TP) begin
                    loaded = 1'b1;
                    readCount = 0;
                    for (int k = 0; k < NB; k++) begin
                        for (int n = 0; n < 5; n++) b[n] = tilePix[5 * k + n];
                        beatQ.push_back(b);
                    end
                end
            end
        end else if (rd) begin
            readCount++;
            if (readCount == OP) begin
                loaded = 1'b0;
                inRst = 1'b1;
                accepted = 0;
                tilesDone++;
                d.cnt = 8'(tilesDone);
                d.edgeNo = edgeCnt;
                doneQ.push_back(d);
            end
        end
        expFill = !loaded && !inRst;
    endtask

    task automatic applyStimulus(input bit v, input logic [BL-1:0] p, input bit rd);
        bus.pix_valid = v;
        bus.pix_in = p;
        bus.readable = rd;
        @(posedge clk);
        #1;
        modelEdge(v, p, rd);
    endtask

    task automatic applyReset();
        bus.pix_valid = 1'b1;
        bus.pix_in = 5'd31;
        bus.readable = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.pix_valid = 1'b0;
        bus.readable = 1'b0;
        accepted = 0;
        loaded = 1'b0;
        inRst = 1'b0;
        readCount = 0;
        tilesDone = 0;
        expFill = 1'b1;
        beatQ.delete();
        doneQ.delete();
    endtask

    // mode 0: contiguous index pattern, 1: index pattern on alternate cycles, 2: random values and gaps
    task automatic fillTile(input int mode);
        bit v;
        logic [BL-1:0] p;
        bit toggle = 1'b1;
        int guard = 0;
        while (!loaded && guard < 4 * TP) begin
            case (mode)
                0: v = 1'b1;
                1: begin v = toggle; toggle = !toggle; end
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            p = (mode < 2) ? BL'(accepted % 32) : BL'($urandom_range(0, 31));
            applyStimulus(v, p, $urandom_range(0, 1) == 1);
            guard++;
        end
    endtask

    task automatic drainTile(input bit validInStream);
        int guard = 0;
        while (loaded && guard < 20 * OP) begin
            applyStimulus(validInStream, BL'($urandom_range(0, 31)), $urandom_range(0, 99) < 70);
            guard++;
        end
        applyStimulus(1'b0, '0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (started && !reset) begin
            checkOutput("pix_ready", bus.pix_ready, expFill);
            if (bus.tile_done === 1'b1) begin
                if (doneQ.size() == 0) begin
                    checkOutput("spurious_tile_done", bus.tile_done, 0);
                end else begin
                    done_t d;
                    d = doneQ.pop_front();
                    checkOutput("tile_cnt", bus.tile_cnt, d.cnt);
                    checkOutput("tile_done_cycle", edgeCnt, d.edgeNo);
                    checkOutput("chip_rst", bus.chip_rst, 1);
                    checkOutput("load_end_in_rst", bus.load_end, 0);
                    checkOutput("lanes_in_rst", {bus.pixel_out4, bus.pixel_out3, bus.pixel_out2,
                                                 bus.pixel_out1, bus.pixel_out0}, 0);
                end
            end else if (bus.pix_ready === 1'b1) begin
                beatSeen = 0;
                checkOutput("chip_rst_idle", bus.chip_rst, 0);
            end else if (beatSeen < NB) begin
                if (beatQ.size() == 0) begin
                    checkOutput("spurious_beat", bus.pix_ready, 1);
                end else begin
                    beat_t b;
                    b = beatQ.pop_front();
                    checkOutput($sformatf("beat%0d_lanes", beatSeen),
                                {bus.pixel_out4, bus.pixel_out3, bus.pixel_out2,
                                 bus.pixel_out1, bus.pixel_out0}, b);
                    checkOutput($sformatf("beat%0d_load_end", beatSeen), bus.load_end,
                                (beatSeen == NB - 1) ? 1 : 0);
                    lastBeat = b;
                end
                beatSeen++;
            end else begin
                checkOutput("hold_lanes", {bus.pixel_out4, bus.pixel_out3, bus.pixel_out2,
                                           bus.pixel_out1, bus.pixel_out0}, lastBeat);
                checkOutput("hold_load_end", bus.load_end, 1);
            end
        end
    end

    always @(negedge clk) begin
        if (smallRunning && !resetS && busS.tile_done === 1'b1) begin
            smallDone++;
            checkOutput($sformatf("wrap_tile_cnt_%0d", smallDone), busS.tile_cnt, smallDone % 256);
        end
    end

    // Small instance: pixels and reads always offered, so each tile takes STP + SOP + 1 edges
    initial begin
        busS.pix_valid = 1'b0;
        busS.pix_in = '0;
        busS.readable = 1'b0;
        resetS = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        resetS = 1'b0;
        smallRunning = 1'b1;
        busS.pix_valid = 1'b1;
        busS.readable = 1'b1;
        repeat (SMALL_TILES * (STP + SOP + 1)) begin
            busS.pix_in = BL'($urandom_range(0, 31));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("wrap_tiles_seen", smallDone, SMALL_TILES);
        checkOutput("wrap_final_tile_cnt", busS.tile_cnt, 1);
        smallFinished = 1'b1;
    end

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_in = '0;
        bus.readable = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        started = 1'b1;
        checkOutput("reset_pix_ready", bus.pix_ready, 1);
        checkOutput("reset_lanes", {bus.pixel_out4, bus.pixel_out3, bus.pixel_out2,
                                    bus.pixel_out1, bus.pixel_out0}, 0);
        checkOutput("reset_load_end", bus.load_end, 0);
        checkOutput("reset_chip_rst", bus.chip_rst, 0);
        checkOutput("reset_tile_done", bus.tile_done, 0);
        checkOutput("reset_tile_cnt", bus.tile_cnt, 0);

        $display("[TB] tile 1: contiguous index pattern");
        fillTile(0);
        drainTile(1'b0);
        $display("[TB] tile 2: alternate-cycle valid, valid held during stream");
        fillTile(1);
        drainTile(1'b1);
        $display("[TB] tile 3: random pixels and gaps");
        fillTile(2);
        drainTile(1'b1);

        $display("[TB] reset at beat 40");
        fillTile(2);
        repeat (40) applyStimulus(1'b0, '0, $urandom_range(0, 1) == 1);
        applyReset();
        checkOutput("abort_lanes", {bus.pixel_out4, bus.pixel_out3, bus.pixel_out2,
                                    bus.pixel_out1, bus.pixel_out0}, 0);
        checkOutput("abort_load_end", bus.load_end, 0);
        checkOutput("abort_pix_ready", bus.pix_ready, 1);
        checkOutput("abort_tile_done", bus.tile_done, 0);
        checkOutput("abort_chip_rst", bus.chip_rst, 0);
        checkOutput("abort_tile_cnt", bus.tile_cnt, 0);

        $display("[TB] fresh tile after abort");
        fillTile(0);
        drainTile(1'b0);
        repeat (4) applyStimulus(1'b0, '0, 1'b1);

        fork
            wait (smallFinished);
            repeat (20000) @(posedge clk);
        join_any
        disable fork;
        checkOutput("wrap_run_finished", smallFinished, 1);
        checkOutput("beats_outstanding", beatQ.size(), 0);
        checkOutput("drains_outstanding", doneQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
